// File: rtl/sensemi_regs_pkg.sv
// Shared types, response codes and width helpers for the AXI4-Lite register bridge.
package sensemi_regs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_EXEC,
        ST_WR_RESP,
        ST_RD_EXEC,
        ST_RD_WAIT,
        ST_RD_RESP
    } regs_bridge_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int unsigned ofs_w(input int unsigned bank_addr_width,
                                          input int unsigned data_width);
        return bank_addr_width - addr_lsb(data_width);
    endfunction

    // A single bank still needs a 1-bit index signal.
    function automatic int unsigned bank_w(input int unsigned num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/sensemi_regs_addr_decode.sv
// Combinational split of an AXI byte address into bank index, word offset and mapped flag.
module sensemi_regs_addr_decode #(
    parameter int unsigned AXI_ADDR_WIDTH  = 13,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned BANK_ADDR_WIDTH = 11,
    parameter int unsigned ADDR_LSB        = 2,
    parameter int unsigned OFS_W           = 9,
    parameter int unsigned BANK_W          = 2
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    output logic [BANK_W-1:0]         bank,
    output logic [OFS_W-1:0]          offset,
    output logic                      mapped
);

    localparam int unsigned SEL_W = $clog2(NUM_BANKS);
    localparam int unsigned TOP   = BANK_ADDR_WIDTH + SEL_W;

    logic unused_lsb;

    assign offset     = addr[BANK_ADDR_WIDTH-1:ADDR_LSB];
    assign unused_lsb = ^addr[ADDR_LSB-1:0];

    generate
        if (SEL_W > 0) begin : g_bank_sel
            assign bank = addr[BANK_ADDR_WIDTH +: SEL_W];
        end else begin : g_bank_single
            assign bank = '0;
        end

        // Anything above the last bank is outside the decoded window.
        if (TOP < AXI_ADDR_WIDTH) begin : g_map_chk
            assign mapped = ~|addr[AXI_ADDR_WIDTH-1:TOP];
        end else begin : g_map_all
            assign mapped = 1'b1;
        end
    endgenerate

endmodule

// File: rtl/sensemi_axil_regs_bridge.sv
// AXI4-Lite slave bridging to a multi-bank strobe/offset register bus,
// one transaction in flight, round-robin between write and read.
module sensemi_axil_regs_bridge
    import sensemi_regs_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH  = 13,
    parameter int unsigned AXI_DATA_WIDTH  = 32,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned BANK_ADDR_WIDTH = 11,
    parameter int unsigned RD_LATENCY      = 1
) (
    input  logic                                          s_axi_aclk,
    input  logic                                          s_axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]                     s_axi_awaddr,
    input  logic [2:0]                                    s_axi_awprot,
    input  logic                                          s_axi_awvalid,
    output logic                                          s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]                     s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]                   s_axi_wstrb,
    input  logic                                          s_axi_wvalid,
    output logic                                          s_axi_wready,
    output logic [1:0]                                    s_axi_bresp,
    output logic                                          s_axi_bvalid,
    input  logic                                          s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]                     s_axi_araddr,
    input  logic [2:0]                                    s_axi_arprot,
    input  logic                                          s_axi_arvalid,
    output logic                                          s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]                     s_axi_rdata,
    output logic [1:0]                                    s_axi_rresp,
    output logic                                          s_axi_rvalid,
    input  logic                                          s_axi_rready,
    output logic [NUM_BANKS-1:0]                          reg_wren,
    output logic [ofs_w(BANK_ADDR_WIDTH, AXI_DATA_WIDTH)-1:0] reg_wr_offset,
    output logic [AXI_DATA_WIDTH-1:0]                     reg_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]                   reg_wstrb,
    output logic [NUM_BANKS-1:0]                          reg_rden,
    output logic [ofs_w(BANK_ADDR_WIDTH, AXI_DATA_WIDTH)-1:0] reg_rd_offset,
    input  logic [NUM_BANKS*AXI_DATA_WIDTH-1:0]           reg_rdata
);

    localparam int unsigned ADDR_LSB = addr_lsb(AXI_DATA_WIDTH);
    localparam int unsigned OFS_W    = ofs_w(BANK_ADDR_WIDTH, AXI_DATA_WIDTH);
    localparam int unsigned BANK_W   = bank_w(NUM_BANKS);
    localparam logic [NUM_BANKS-1:0] BANK_ONE = NUM_BANKS'(1);

    regs_bridge_state_t         state;
    logic                       last_wr;
    logic                       wr_err;
    logic                       rd_err;
    logic [BANK_W-1:0]          rd_bank;
    logic [2:0]                 lat_cnt;
    logic                       grant_wr;
    logic                       grant_rd;
    logic [BANK_W-1:0]          wr_bank_d;
    logic [OFS_W-1:0]           wr_ofs_d;
    logic                       wr_mapped;
    logic [BANK_W-1:0]          rd_bank_d;
    logic [OFS_W-1:0]           rd_ofs_d;
    logic                       rd_mapped;
    logic [AXI_DATA_WIDTH-1:0]  bank_rdata [NUM_BANKS];
    logic [AXI_DATA_WIDTH-1:0]  rd_sel;
    logic                       unused_prot;

    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    sensemi_regs_addr_decode #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .NUM_BANKS      (NUM_BANKS),
        .BANK_ADDR_WIDTH(BANK_ADDR_WIDTH),
        .ADDR_LSB       (ADDR_LSB),
        .OFS_W          (OFS_W),
        .BANK_W         (BANK_W)
    ) u_wr_dec (
        .addr  (s_axi_awaddr),
        .bank  (wr_bank_d),
        .offset(wr_ofs_d),
        .mapped(wr_mapped)
    );

    sensemi_regs_addr_decode #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .NUM_BANKS      (NUM_BANKS),
        .BANK_ADDR_WIDTH(BANK_ADDR_WIDTH),
        .ADDR_LSB       (ADDR_LSB),
        .OFS_W          (OFS_W),
        .BANK_W         (BANK_W)
    ) u_rd_dec (
        .addr  (s_axi_araddr),
        .bank  (rd_bank_d),
        .offset(rd_ofs_d),
        .mapped(rd_mapped)
    );

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank_rdata
        assign bank_rdata[b] = reg_rdata[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end

    assign rd_sel = bank_rdata[rd_bank];

    // Ready is pre-registered one cycle ahead; a read wins a tie only if a write was served last.
    always_comb begin
        grant_wr = s_axi_awvalid && s_axi_wvalid && (!s_axi_arvalid || !last_wr);
        grant_rd = s_axi_arvalid && !grant_wr;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state         <= ST_IDLE;
            last_wr       <= 1'b0;
            wr_err        <= 1'b0;
            rd_err        <= 1'b0;
            rd_bank       <= '0;
            lat_cnt       <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= '0;
            reg_wren      <= '0;
            reg_rden      <= '0;
            reg_wr_offset <= '0;
            reg_rd_offset <= '0;
            reg_wdata     <= '0;
            reg_wstrb     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_axi_awready && s_axi_awvalid && s_axi_wvalid) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        last_wr       <= 1'b1;
                        wr_err        <= !wr_mapped;
                        if (wr_mapped) begin
                            reg_wren      <= BANK_ONE << wr_bank_d;
                            reg_wr_offset <= wr_ofs_d;
                            reg_wdata     <= s_axi_wdata;
                            reg_wstrb     <= s_axi_wstrb;
                        end
                        state <= ST_WR_EXEC;
                    end else if (s_axi_arready && s_axi_arvalid) begin
                        s_axi_arready <= 1'b0;
                        last_wr       <= 1'b0;
                        rd_err        <= !rd_mapped;
                        rd_bank       <= rd_bank_d;
                        if (rd_mapped) begin
                            reg_rden      <= BANK_ONE << rd_bank_d;
                            reg_rd_offset <= rd_ofs_d;
                        end
                        state <= ST_RD_EXEC;
                    end else begin
                        s_axi_awready <= grant_wr;
                        s_axi_wready  <= grant_wr;
                        s_axi_arready <= grant_rd;
                    end
                end
                ST_WR_EXEC: begin
                    reg_wren     <= '0;
                    s_axi_bvalid <= 1'b1;
                    s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
                    state        <= ST_WR_RESP;
                end
                ST_WR_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= grant_wr;
                        s_axi_wready  <= grant_wr;
                        s_axi_arready <= grant_rd;
                        state         <= ST_IDLE;
                    end
                end
                ST_RD_EXEC: begin
                    reg_rden <= '0;
                    if (RD_LATENCY == 0) begin
                        s_axi_rdata  <= rd_err ? '0 : rd_sel;
                        s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        s_axi_rvalid <= 1'b1;
                        state        <= ST_RD_RESP;
                    end else begin
                        // The EXEC cycle itself is the first latency cycle.
                        lat_cnt <= 3'(RD_LATENCY - 1);
                        state   <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        s_axi_rdata  <= rd_err ? '0 : rd_sel;
                        s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        s_axi_rvalid <= 1'b1;
                        state        <= ST_RD_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                ST_RD_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_awready <= grant_wr;
                        s_axi_wready  <= grant_wr;
                        s_axi_arready <= grant_rd;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensemi_axil_regs_bridge.sv
// Directed bench for the AXI4-Lite register bridge: 4 banks of 2 KiB in a 14-bit space, read latency 2.
module tb_sensemi_axil_regs_bridge;

    localparam int unsigned AW  = 14;
    localparam int unsigned DW  = 32;
    localparam int unsigned NB  = 4;
    localparam int unsigned BAW = 11;
    localparam int unsigned RL  = 2;
    localparam int unsigned OW  = 9;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    logic [NB-1:0]   reg_wren;
    logic [OW-1:0]   reg_wr_offset;
    logic [DW-1:0]   reg_wdata;
    logic [DW/8-1:0] reg_wstrb;
    logic [NB-1:0]   reg_rden;
    logic [OW-1:0]   reg_rd_offset;
    logic [NB*DW-1:0] reg_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sensemi_axil_regs_bridge #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .NUM_BANKS      (NB),
        .BANK_ADDR_WIDTH(BAW),
        .RD_LATENCY     (RL)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .s_axi_awaddr (awaddr),
        .s_axi_awprot (awprot),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_araddr (araddr),
        .s_axi_arprot (arprot),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .reg_wren     (reg_wren),
        .reg_wr_offset(reg_wr_offset),
        .reg_wdata    (reg_wdata),
        .reg_wstrb    (reg_wstrb),
        .reg_rden     (reg_rden),
        .reg_rd_offset(reg_rd_offset),
        .reg_rdata    (reg_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_awready"}, 64'(awready), 64'd0);
        chk({tag, "_wready"},  64'(wready),  64'd0);
        chk({tag, "_arready"}, 64'(arready), 64'd0);
        chk({tag, "_bvalid"},  64'(bvalid),  64'd0);
        chk({tag, "_rvalid"},  64'(rvalid),  64'd0);
        chk({tag, "_bresp"},   64'(bresp),   64'd0);
        chk({tag, "_rresp"},   64'(rresp),   64'd0);
        chk({tag, "_rdata"},   64'(rdata),   64'd0);
        chk({tag, "_wren"},    64'(reg_wren), 64'd0);
        chk({tag, "_rden"},    64'(reg_rden), 64'd0);
        chk({tag, "_wr_ofs"},  64'(reg_wr_offset), 64'd0);
        chk({tag, "_rd_ofs"},  64'(reg_rd_offset), 64'd0);
        chk({tag, "_wdata"},   64'(reg_wdata), 64'd0);
        chk({tag, "_wstrb"},   64'(reg_wstrb), 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        awaddr  = '0; awprot = '0; awvalid = 1'b0;
        wdata   = '0; wstrb  = '0; wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0; arprot = '0; arvalid = 1'b0;
        rready  = 1'b1;
        reg_rdata = {32'hC333_3333, 32'hBAD0_0002, 32'hB111_1111, 32'hA000_0000};

        repeat (2) nx();
        chk_zero_outputs("in_reset");
        rst_n = 1'b1;
        nx();
        chk_zero_outputs("after_reset");

        // Both pending after reset: write first, then read, then the second write.
        awaddr = 14'h0000; wdata = 32'h1111_1111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 14'h1800; arvalid = 1'b1;
        nx();
        chk("arb_awready", 64'(awready), 64'd1);
        chk("arb_wready",  64'(wready),  64'd1);
        chk("arb_arready_low", 64'(arready), 64'd0);
        nx();
        chk("arb_wren", 64'(reg_wren), 64'h1);
        chk("arb_wr_ofs", 64'(reg_wr_offset), 64'd0);
        chk("arb_wdata", 64'(reg_wdata), 64'h1111_1111);
        chk("arb_awready_drop", 64'(awready), 64'd0);
        awaddr = 14'h0008; wdata = 32'h2222_2222; wstrb = 4'h3;
        nx();
        chk("arb_bvalid", 64'(bvalid), 64'd1);
        chk("arb_bresp", 64'(bresp), 64'd0);
        chk("arb_wren_pulse", 64'(reg_wren), 64'd0);
        nx();
        chk("arb_rd_second_arready", 64'(arready), 64'd1);
        chk("arb_rd_second_awready", 64'(awready), 64'd0);
        nx();
        arvalid = 1'b0;
        chk("arb_rden", 64'(reg_rden), 64'h8);
        chk("arb_rd_ofs", 64'(reg_rd_offset), 64'd0);
        nx();
        chk("arb_one_outstanding", 64'(awready), 64'd0);
        nx();
        chk("arb_rvalid_early", 64'(rvalid), 64'd0);
        nx();
        chk("arb_rvalid", 64'(rvalid), 64'd1);
        chk("arb_rdata", 64'(rdata), 64'hC333_3333);
        chk("arb_rresp", 64'(rresp), 64'd0);
        nx();
        chk("arb_wr_third_awready", 64'(awready), 64'd1);
        chk("arb_rvalid_done", 64'(rvalid), 64'd0);
        nx();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("arb_wren2", 64'(reg_wren), 64'h1);
        chk("arb_wr_ofs2", 64'(reg_wr_offset), 64'd2);
        chk("arb_wdata2", 64'(reg_wdata), 64'h2222_2222);
        chk("arb_wstrb2", 64'(reg_wstrb), 64'h3);
        nx();
        chk("arb_bvalid2", 64'(bvalid), 64'd1);
        nx();
        chk("arb_bvalid2_done", 64'(bvalid), 64'd0);

        // Unmapped write above the last bank.
        awaddr = 14'h2000; wdata = 32'h3333_3333; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        nx();
        chk("unm_wr_awready", 64'(awready), 64'd1);
        nx();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("unm_wr_no_wren", 64'(reg_wren), 64'd0);
        nx();
        chk("unm_wr_bvalid", 64'(bvalid), 64'd1);
        chk("unm_wr_bresp", 64'(bresp), 64'h2);
        chk("unm_wr_no_wren2", 64'(reg_wren), 64'd0);
        nx();
        chk("unm_wr_bvalid_done", 64'(bvalid), 64'd0);

        // Unmapped read.
        araddr = 14'h3FFC; arvalid = 1'b1;
        nx();
        chk("unm_rd_arready", 64'(arready), 64'd1);
        nx();
        arvalid = 1'b0;
        chk("unm_rd_no_rden", 64'(reg_rden), 64'd0);
        nx();
        chk("unm_rd_no_rden2", 64'(reg_rden), 64'd0);
        nx();
        chk("unm_rd_rvalid_early", 64'(rvalid), 64'd0);
        nx();
        chk("unm_rd_rvalid", 64'(rvalid), 64'd1);
        chk("unm_rd_rdata", 64'(rdata), 64'd0);
        chk("unm_rd_rresp", 64'(rresp), 64'h2);
        nx();
        chk("unm_rd_rvalid_done", 64'(rvalid), 64'd0);

        // Mapped write to bank 1, word 1.
        awaddr = 14'h0804; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        nx();
        chk("wr_awready", 64'(awready), 64'd1);
        nx();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_wren", 64'(reg_wren), 64'h2);
        chk("wr_ofs", 64'(reg_wr_offset), 64'd1);
        chk("wr_wdata", 64'(reg_wdata), 64'hDEAD_BEEF);
        chk("wr_wstrb", 64'(reg_wstrb), 64'hF);
        chk("wr_bvalid_early", 64'(bvalid), 64'd0);
        nx();
        chk("wr_bvalid", 64'(bvalid), 64'd1);
        chk("wr_bresp", 64'(bresp), 64'd0);
        nx();
        chk("wr_bvalid_done", 64'(bvalid), 64'd0);

        // Mapped read of bank 2, word 2; bank data is only correct in the sampling cycle.
        rready = 1'b0;
        araddr = 14'h1008; arvalid = 1'b1;
        nx();
        chk("rd_arready", 64'(arready), 64'd1);
        nx();
        arvalid = 1'b0;
        chk("rd_rden", 64'(reg_rden), 64'h4);
        chk("rd_ofs", 64'(reg_rd_offset), 64'd2);
        nx();
        chk("rd_rden_pulse", 64'(reg_rden), 64'd0);
        chk("rd_rvalid_t2", 64'(rvalid), 64'd0);
        nx();
        reg_rdata[64 +: 32] = 32'h1234_5678;
        chk("rd_rvalid_t3", 64'(rvalid), 64'd0);
        nx();
        reg_rdata[64 +: 32] = 32'hBAD0_0002;
        chk("rd_rvalid", 64'(rvalid), 64'd1);
        chk("rd_rdata", 64'(rdata), 64'h1234_5678);
        chk("rd_rresp", 64'(rresp), 64'd0);
        nx();
        chk("rd_rvalid_hold", 64'(rvalid), 64'd1);
        chk("rd_rdata_hold", 64'(rdata), 64'h1234_5678);
        rready = 1'b1;
        nx();
        chk("rd_rvalid_done", 64'(rvalid), 64'd0);

        // Zero-strobe write under bready backpressure, with another write waiting.
        bready = 1'b0;
        awaddr = 14'h0C00; wdata = 32'h4444_4444; wstrb = 4'h0; awvalid = 1'b1; wvalid = 1'b1;
        nx();
        chk("bp_awready", 64'(awready), 64'd1);
        nx();
        chk("bp_wren", 64'(reg_wren), 64'h2);
        chk("bp_wr_ofs", 64'(reg_wr_offset), 64'h100);
        chk("bp_wstrb", 64'(reg_wstrb), 64'h0);
        chk("bp_wdata", 64'(reg_wdata), 64'h4444_4444);
        awaddr = 14'h0004; wdata = 32'h5555_5555; wstrb = 4'hF;
        for (int i = 0; i < 10; i++) begin
            nx();
            chk("bp_bvalid_hold", 64'(bvalid), 64'd1);
            chk("bp_bresp_hold", 64'(bresp), 64'd0);
            chk("bp_no_awready", 64'(awready), 64'd0);
        end
        bready = 1'b1;
        nx();
        chk("bp_next_awready", 64'(awready), 64'd1);
        chk("bp_bvalid_done", 64'(bvalid), 64'd0);
        nx();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bp_wren2", 64'(reg_wren), 64'h1);
        chk("bp_wr_ofs2", 64'(reg_wr_offset), 64'd1);
        chk("bp_wdata2", 64'(reg_wdata), 64'h5555_5555);
        nx();
        chk("bp_bvalid2", 64'(bvalid), 64'd1);
        nx();
        chk("bp_bvalid2_done", 64'(bvalid), 64'd0);

        // Reset while the read is waiting on bank latency.
        reg_rdata[64 +: 32] = 32'h1234_5678;
        araddr = 14'h1008; arvalid = 1'b1;
        nx();
        chk("rst_arready", 64'(arready), 64'd1);
        nx();
        arvalid = 1'b0;
        chk("rst_rden", 64'(reg_rden), 64'h4);
        nx();
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("rst_async");
        nx();
        nx();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nx();
            chk("rst_no_rvalid", 64'(rvalid), 64'd0);
            chk("rst_no_rden", 64'(reg_rden), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
